// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmit FIFO feeding a start/data/parity/stop frame generator
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATA_BITS-1:0] Tx_Data,
  input  logic                 Write_En,
  input  logic                 Tx_Enable,
  output logic                 Tx,
  output logic                 Tx_Busy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow
);
  localparam int   PW        = $clog2(FIFO_DEPTH);
  localparam int   CW        = PW + 1;
  localparam int   BW        = $clog2(CLKS_PER_BIT);
  localparam int   NW        = $clog2(DATA_BITS);
  localparam logic ODD       = (PARITY == 2);
  localparam logic HAS_PAR   = (PARITY != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_d;
  logic                 wr_ok, pop, can_pop, bit_end;
  logic [DATA_BITS-1:0] head;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [NW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 par_q, par_d;
  logic                 tx_d;

  // Writes are judged against the pre-edge full flag, so a same-edge pop never rescues one
  assign wr_ok   = Write_En & ~FIFO_Full;
  assign head    = mem[rd_ptr];
  assign can_pop = Tx_Enable & ~FIFO_Empty;
  assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign Tx_Busy = (state_q != S_IDLE);

  // Storage array carries no reset; only pointers and count define its contents
  always_ff @(posedge Clk) begin
    if (wr_ok) mem[wr_ptr] <= Tx_Data;
  end

  // Next occupancy: a simultaneous write and pop leaves the count unchanged
  always_comb begin
    count_d = count;
    if (wr_ok && !pop)      count_d = count + CW'(1);
    else if (!wr_ok && pop) count_d = count - CW'(1);
  end

  // FIFO pointers, occupancy and registered flags
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      FIFO_Empty    <= 1'b1;
      FIFO_Full     <= 1'b0;
      FIFO_Overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count         <= count_d;
      FIFO_Empty    <= (count_d == '0);
      FIFO_Full     <= (count_d == CW'(FIFO_DEPTH));
      FIFO_Overflow <= Write_En & FIFO_Full;
    end
  end

  // Frame sequencing; a pop from IDLE or the last stop cycle loads the next byte and starts a frame
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BW'(1);
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (can_pop) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == NW'(DATA_BITS - 1)) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + NW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            if (can_pop) pop = 1'b1;
            else         state_d = S_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ ODD;
      bit_d   = '0;
      stop_d  = 1'b0;
      baud_d  = '0;
      state_d = S_START;
    end
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // FSM state, datapath registers and the registered serial line
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      Tx      <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      Tx      <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (even/1-stop and odd/2-stop instances)
module tb_uart_tx_fifo;
  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] data_a, data_b;
  logic       we_a, we_b, en_a, en_b;
  logic       tx_a, busy_a, empty_a, full_a, ovf_a;
  logic       tx_b, busy_b, empty_b, full_b, ovf_b;

  typedef struct {logic [7:0] d; logic p;} exp_t;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int   start_a[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rst_epoch = 0;
  int   frames_a = 0;
  int   frames_b = 0;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut_a (
    .Clk(Clk), .Rst(Rst), .Tx_Data(data_a), .Write_En(we_a), .Tx_Enable(en_a),
    .Tx(tx_a), .Tx_Busy(busy_a), .FIFO_Empty(empty_a), .FIFO_Full(full_a), .FIFO_Overflow(ovf_a));

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .Tx_Data(data_b), .Write_En(we_b), .Tx_Enable(en_b),
    .Tx(tx_b), .Tx_Busy(busy_b), .FIFO_Empty(empty_b), .FIFO_Full(full_b), .FIFO_Overflow(ovf_b));

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic txv(input bit b);
    return b ? tx_b : tx_a;
  endfunction

  // Serial receiver model: decodes one frame per start bit and pops the scoreboard
  task automatic monitor(input bit b);
    int         ep, stops, ones;
    logic [7:0] d;
    logic       s0, p;
    exp_t       e;
    stops = b ? 2 : 1;
    forever begin
      @(negedge Clk);
      if (txv(b) == 1'b0) begin
        ep = rst_epoch;
        if (!b) start_a.push_back(cyc);
        repeat (2) @(negedge Clk);
        s0 = txv(b);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge Clk);
          d[i] = txv(b);
        end
        repeat (4) @(negedge Clk);
        p = txv(b);
        repeat (2) @(negedge Clk);
        ones = 0;
        for (int i = 0; i < 4 * stops; i++) begin
          if (i > 0) @(negedge Clk);
          if (txv(b)) ones++;
        end
        if (ep == rst_epoch) begin
          if (b) frames_b++; else frames_a++;
          if ((b ? exp_b.size() : exp_a.size()) == 0) begin
            chk(b ? "b_unexpected_frame" : "a_unexpected_frame", {24'h0, d}, 32'hFFFF_FFFF);
          end else begin
            e = b ? exp_b.pop_front() : exp_a.pop_front();
            chk(b ? "b_start" : "a_start", s0, 0);
            chk(b ? "b_data" : "a_data", d, e.d);
            chk(b ? "b_parity" : "a_parity", p, e.p);
            chk(b ? "b_stop_cycles" : "a_stop_cycles", ones, 4 * stops);
          end
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  task automatic wr_a(input logic [7:0] d, input logic p, input bit accepted);
    data_a = d;
    we_a   = 1'b1;
    if (accepted) exp_a.push_back('{d, p});
    @(negedge Clk);
    we_a = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] d, input logic p);
    data_b = d;
    we_b   = 1'b1;
    exp_b.push_back('{d, p});
    @(negedge Clk);
    we_b = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  initial begin
    int busy_n, f0, ones, n;
    Rst = 1'b1; data_a = 8'h00; data_b = 8'h00;
    we_a = 1'b0; we_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_ovf", ovf_a, 0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    // single frame 0xA5, even parity
    wr_a(8'hA5, 1'b0, 1'b1);
    chk("t1_empty_after_write", empty_a, 0);
    chk("t1_tx_idle_after_write", tx_a, 1);
    @(negedge Clk);
    chk("t1_tx_start", tx_a, 0);
    chk("t1_busy_start", busy_a, 1);
    busy_n = 1;
    for (int i = 1; i < 44; i++) begin
      @(negedge Clk);
      if (busy_a) busy_n++;
    end
    chk("t1_busy_cycles", busy_n, 44);
    @(negedge Clk);
    chk("t1_busy_cycle45", busy_a, 0);
    drain("t1_drain", 200);
    chk("t1_frames", frames_a, 1);

    // odd parity, two stop bits
    wr_b(8'h01, 1'b0);
    drain("t2_drain", 200);
    chk("t2_frames", frames_b, 1);

    // overflow with transmitter disabled
    en_a = 1'b0;
    f0 = frames_a;
    wr_a(8'h11, 1'b0, 1'b1);
    wr_a(8'h22, 1'b0, 1'b1);
    wr_a(8'h33, 1'b0, 1'b1);
    wr_a(8'h44, 1'b0, 1'b1);
    chk("t3_full_after_4", full_a, 1);
    chk("t3_no_ovf_yet", ovf_a, 0);
    wr_a(8'h55, 1'b0, 1'b0);
    chk("t3_ovf_pulse", ovf_a, 1);
    @(negedge Clk);
    chk("t3_ovf_cleared", ovf_a, 0);
    chk("t3_still_full", full_a, 1);
    chk("t3_no_tx_while_disabled", busy_a, 0);
    en_a = 1'b1;
    drain("t3_drain", 400);
    chk("t3_frames", frames_a - f0, 4);

    // back-to-back frames with pointer wrap
    f0 = frames_a;
    wr_a(8'h01, 1'b1, 1'b1);
    wr_a(8'h80, 1'b1, 1'b1);
    wr_a(8'hFF, 1'b0, 1'b1);
    wr_a(8'h00, 1'b0, 1'b1);
    repeat (30) @(negedge Clk);
    wr_a(8'h7E, 1'b0, 1'b1);
    repeat (30) @(negedge Clk);
    wr_a(8'h3B, 1'b1, 1'b1);
    drain("t4_drain", 600);
    chk("t4_frames", frames_a - f0, 6);
    n = start_a.size();
    for (int k = 1; k < 6; k++) chk("t4_gapless", start_a[n-6+k] - start_a[n-6+k-1], 44);

    // Tx_Enable dropped mid-DATA with two entries queued
    f0 = frames_a;
    wr_a(8'hC3, 1'b0, 1'b1);
    wr_a(8'h96, 1'b0, 1'b1);
    wr_a(8'h07, 1'b1, 1'b1);
    repeat (10) @(negedge Clk);
    en_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("t5_frame_completes", n < 100, 1);
    chk("t5_one_frame", frames_a - f0, 1);
    chk("t5_not_empty", empty_a, 0);
    chk("t5_not_full", full_a, 0);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (tx_a && !busy_a) ones++;
    end
    chk("t5_parked_idle", ones, 20);
    chk("t5_no_frame_while_parked", frames_a - f0, 1);
    en_a = 1'b1;
    @(negedge Clk);
    chk("t5_resume_tx", tx_a, 0);
    chk("t5_resume_busy", busy_a, 1);
    drain("t5_drain", 300);
    chk("t5_frames", frames_a - f0, 3);

    // asynchronous reset mid-frame with three entries queued
    wr_a(8'h5A, 1'b0, 1'b1);
    wr_a(8'h12, 1'b0, 1'b1);
    wr_a(8'h34, 1'b1, 1'b1);
    wr_a(8'h56, 1'b0, 1'b1);
    repeat (16) @(negedge Clk);
    f0 = frames_a;
    #2;
    Rst = 1'b1;
    rst_epoch++;
    exp_a.delete();
    #1;
    chk("t6_rst_tx", tx_a, 1);
    chk("t6_rst_empty", empty_a, 1);
    chk("t6_rst_busy", busy_a, 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (200) @(negedge Clk);
    chk("t6_no_frames_after_reset", frames_a - f0, 0);
    chk("t6_idle_after_reset", busy_a, 0);
    chk("t6_tx_high", tx_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmit path: a host-side write FIFO feeding a serialising frame generator. It is the transmit-direction counterpart of the receive FIFO. The host pushes parallel bytes with a single-cycle write strobe. The block emits standard asynchronous frames on the serial line: start bit, DATA_BITS LSB-first, optional parity, then stop bit(s).

## Interface
- DATA_BITS, 8, payload width per frame (5..9)
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥2)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, number of stop bits (1 or 2)

- Clk  input  1  system clock; all state updates on its rising edge
- Rst  input  1  asynchronous, active-high reset
- Tx_Data  input  DATA_BITS  byte to enqueue
- Write_En  input  1  enqueue strobe, sampled each rising Clk edge
- Tx_Enable  input  1  when low, no new frame starts; a frame in progress completes
- Tx  output  1  serial line; idle/mark = 1
- Tx_Busy  output  1  high while a frame is on the line (FSM not IDLE)
- FIFO_Empty  output  1  no entries queued
- FIFO_Full  output  1  FIFO_DEPTH entries queued
- FIFO_Overflow  output  1  one-cycle pulse when a write is dropped

## Operation
- FIFO: circular buffer with read/write pointers and a 0..FIFO_DEPTH occupancy count (width clog2(FIFO_DEPTH)+1). Pointers wrap modulo FIFO_DEPTH.
- Write accept: Write_En=1 and FIFO_Full=0 at the edge. The data is stored, the write pointer advances, and the count increments.
- Write reject: Write_En=1 and FIFO_Full=1. The data is dropped and FIFO_Overflow=1 for the following cycle only. FIFO contents are unchanged. A pop on the same edge does not rescue the write; FIFO_Full is evaluated pre-edge.
- Write and pop on the same edge: the count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1. If Tx_Enable=1 and FIFO_Empty=0, pop the head into the shift register, clear the bit counter, go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: Tx = shift[0]. After each CLKS_PER_BIT cycles, shift right. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: Tx = XOR of the payload (even), or its inverse (odd), for CLKS_PER_BIT cycles. Parity is computed at pop time.
  - STOP: Tx=1 for STOP_BITS×CLKS_PER_BIT cycles. At the final cycle:
    - if Tx_Enable=1 and the FIFO is non-empty, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state entry.
- Tx is registered, with no combinational path from inputs to Tx.
- Tx_Enable deasserted mid-frame: the current frame finishes; the FSM then parks in IDLE with the FIFO retained.

## Timing
- Reset values, all asynchronous:
  - Tx=1, Tx_Busy=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0
  - pointers, count, shift register and baud counter = 0; FSM = IDLE
- Reset mid-frame: Tx returns to 1 immediately and the queued data is flushed.
- Flags: FIFO_Empty and FIFO_Full are registered and reflect the count after the same edge that changes it.
- Latency from an empty, idle FIFO:
  - write accepted at edge k; FIFO_Empty falls after edge k;
  - pop at edge k+1; Tx falls and Tx_Busy rises after edge k+1.
- Frame length: CLKS_PER_BIT×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle.
- Tx_Busy: falls on the edge the FSM enters IDLE.

## Test plan
- Reset: assert Rst mid-frame with 3 entries queued. Require Tx=1, FIFO_Empty=1, Tx_Busy=0 asynchronously. After release, no further frames are sent.
- Single frame (CLKS_PER_BIT=4, PARITY=1, STOP_BITS=1): write 0xA5.
  - Tx=0 starts 1 cycle after the write.
  - Bits, each 4 cycles: 1,0,1,0,0,1,0,1; parity 0; stop 1.
  - Total 44 cycles; Tx_Busy=0 on cycle 45.
- Odd parity with 2 stop bits: write 0x01. Require parity bit 0, and 8 stop cycles at CLKS_PER_BIT=4.
- Overflow: with Tx_Enable=0, write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles.
  - FIFO_Full=1 after the 4th write.
  - FIFO_Overflow pulses once, on the cycle after the 5th write.
  - After Tx_Enable=1, the line carries 0x11,0x22,0x33,0x44 only.
- Back-to-back with wrap: push 6 bytes over time so the pointers wrap. Require gapless frames (stop → start with no idle cycle) and correct order.
- Tx_Enable drop: deassert mid-DATA with 2 entries queued. The current frame completes, Tx stays 1, and the count stays 2. Re-enable: sending resumes 1 cycle later.
